// File: rtl/phold_pkg.sv
// Shared definitions for the PHOLD scheduler: widths, per-core state encoding and
// the packed-bus slice helper.
package phold_pkg;

    localparam int unsigned TW_DEFAULT = 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // Low bit of element idx in a bus packed as idx*width.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/phold_scheduler.sv
// Dispatches queue-head events to idle phold cores, returns their generated events
// through a round-robin arbitrated port and tracks global virtual time.
module phold_scheduler
    import phold_pkg::*;
#(
    parameter int unsigned NCORE = 4,
    parameter int unsigned NIDB  = 3,
    parameter int unsigned TW    = TW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [TW-1:0]         end_time,
    input  logic                  q_valid,
    input  logic [TW-1:0]         q_time,
    input  logic [NIDB-1:0]       q_id,
    output logic                  q_pop,
    output logic [NCORE-1:0]      core_event_valid,
    output logic [NIDB-1:0]       core_event_id,
    output logic [TW-1:0]         core_event_time,
    input  logic [NCORE-1:0]      core_new_ready,
    input  logic [NCORE*TW-1:0]   core_new_time,
    input  logic [NCORE*NIDB-1:0] core_new_target,
    output logic                  out_valid,
    output logic [TW-1:0]         out_time,
    output logic [NIDB-1:0]       out_target,
    input  logic                  out_ready,
    output logic [TW-1:0]         global_time,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    logic [1:0]      state_q       [NCORE];
    logic [1:0]      state_d       [NCORE];
    logic [TW-1:0]   cur_time_q    [NCORE];
    logic [TW-1:0]   cur_time_d    [NCORE];
    logic [TW-1:0]   hold_time_q   [NCORE];
    logic [TW-1:0]   hold_time_d   [NCORE];
    logic [NIDB-1:0] hold_target_q [NCORE];
    logic [NIDB-1:0] hold_target_d [NCORE];

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             lock_q, lock_d;
    logic [IW-1:0]    lock_idx_q, lock_idx_d;
    logic [NCORE-1:0] ev_valid_q, ev_valid_d;
    logic [NIDB-1:0]  ev_id_q, ev_id_d;
    logic [TW-1:0]    ev_time_q, ev_time_d;
    logic [TW-1:0]    gvt_q, gvt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [NCORE-1:0] idle_vec, hold_vec;
    logic [IW-1:0]    disp_idx;
    logic             can_dispatch;
    logic [NCORE-1:0] arb_gnt, grant_oh, accept_vec;
    logic [IW-1:0]    arb_idx, grant_idx;
    logic             accept;
    logic             gvt_any;
    logic [TW-1:0]    gvt_min;
    logic             gvt_regress;
    logic             ready_err;

    always_comb begin
        idle_vec = '0;
        hold_vec = '0;
        disp_idx = '0;
        for (int i = 0; i < int'(NCORE); i++) begin
            idle_vec[i] = (state_q[i] == StIdle);
            hold_vec[i] = (state_q[i] == StHold);
        end
        // Walk downwards so the lowest idle index is the final winner.
        for (int i = int'(NCORE) - 1; i >= 0; i--) begin
            if (idle_vec[i]) disp_idx = IW'(i);
        end
    end

    assign can_dispatch = ~rst & enable & q_valid & (q_time < end_time) & (|idle_vec);
    assign q_pop        = can_dispatch;

    rr_arbiter #(
        .N(NCORE)
    ) u_rr_arbiter (
        .req(hold_vec),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt),
        .idx(arb_idx)
    );

    // A stalled grant is pinned so a late HOLD core cannot steal the port.
    assign grant_idx  = lock_q ? lock_idx_q : arb_idx;
    assign grant_oh   = lock_q ? (NCORE'(1) << lock_idx_q) : arb_gnt;
    assign out_valid  = |hold_vec;
    assign out_time   = hold_time_q[grant_idx];
    assign out_target = hold_target_q[grant_idx];
    assign accept     = out_valid & out_ready;
    assign accept_vec = grant_oh & {NCORE{accept}};

    always_comb begin
        gvt_any = q_valid;
        gvt_min = q_valid ? q_time : '1;
        for (int i = 0; i < int'(NCORE); i++) begin
            if (state_q[i] != StIdle && (!gvt_any || cur_time_q[i] < gvt_min)) begin
                gvt_any = 1'b1;
                gvt_min = cur_time_q[i];
            end
        end
        gvt_regress = gvt_any & (gvt_min < gvt_q);
        gvt_d       = (gvt_any && !gvt_regress) ? gvt_min : gvt_q;
    end

    always_comb begin
        ready_err = 1'b0;
        for (int i = 0; i < int'(NCORE); i++) begin
            state_d[i]       = state_q[i];
            cur_time_d[i]    = cur_time_q[i];
            hold_time_d[i]   = hold_time_q[i];
            hold_target_d[i] = hold_target_q[i];
            if (accept_vec[i]) begin
                state_d[i] = StIdle;
            end
            if (can_dispatch && disp_idx == IW'(i)) begin
                state_d[i]    = StBusy;
                cur_time_d[i] = q_time;
            end
            if (core_new_ready[i]) begin
                if (state_q[i] == StBusy) begin
                    state_d[i]       = StHold;
                    hold_time_d[i]   = core_new_time[slice_lo(i, TW) +: TW];
                    hold_target_d[i] = core_new_target[slice_lo(i, NIDB) +: NIDB];
                end else begin
                    ready_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant_idx == IW'(NCORE - 1)) ? '0 : grant_idx + IW'(1);
        end else if (out_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    always_comb begin
        ev_valid_d = '0;
        ev_id_d    = ev_id_q;
        ev_time_d  = ev_time_q;
        if (can_dispatch) begin
            ev_valid_d[disp_idx] = 1'b1;
            ev_id_d              = q_id;
            ev_time_d            = q_time;
        end
    end

    assign done_d = (&idle_vec) & ~out_valid & (~q_valid | (q_time >= end_time));
    assign err_d  = err_q | ready_err | gvt_regress;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NCORE); i++) begin
                state_q[i]       <= StIdle;
                cur_time_q[i]    <= '0;
                hold_time_q[i]   <= '0;
                hold_target_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            ev_valid_q <= '0;
            ev_id_q    <= '0;
            ev_time_q  <= '0;
            gvt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NCORE); i++) begin
                state_q[i]       <= state_d[i];
                cur_time_q[i]    <= cur_time_d[i];
                hold_time_q[i]   <= hold_time_d[i];
                hold_target_q[i] <= hold_target_d[i];
            end
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            ev_valid_q <= ev_valid_d;
            ev_id_q    <= ev_id_d;
            ev_time_q  <= ev_time_d;
            gvt_q      <= gvt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign core_event_valid = ev_valid_q;
    assign core_event_id    = ev_id_q;
    assign core_event_time  = ev_time_q;
    assign global_time      = gvt_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_phold_scheduler.sv
// Directed bench for phold_scheduler: dispatch, round-robin return, GVT, done and err.
module tb_phold_scheduler;

    localparam int unsigned NCORE = 4;
    localparam int unsigned NIDB  = 3;
    localparam int unsigned TW    = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  enable;
    logic [TW-1:0]         end_time;
    logic                  q_valid;
    logic [TW-1:0]         q_time;
    logic [NIDB-1:0]       q_id;
    logic                  q_pop;
    logic [NCORE-1:0]      core_event_valid;
    logic [NIDB-1:0]       core_event_id;
    logic [TW-1:0]         core_event_time;
    logic [NCORE-1:0]      core_new_ready;
    logic [NCORE*TW-1:0]   core_new_time;
    logic [NCORE*NIDB-1:0] core_new_target;
    logic                  out_valid;
    logic [TW-1:0]         out_time;
    logic [NIDB-1:0]       out_target;
    logic                  out_ready;
    logic [TW-1:0]         global_time;
    logic                  done;
    logic                  err;

    int checks = 0;
    int errors = 0;

    phold_scheduler #(
        .NCORE(NCORE),
        .NIDB (NIDB),
        .TW   (TW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .end_time        (end_time),
        .q_valid         (q_valid),
        .q_time          (q_time),
        .q_id            (q_id),
        .q_pop           (q_pop),
        .core_event_valid(core_event_valid),
        .core_event_id   (core_event_id),
        .core_event_time (core_event_time),
        .core_new_ready  (core_new_ready),
        .core_new_time   (core_new_time),
        .core_new_target (core_new_target),
        .out_valid       (out_valid),
        .out_time        (out_time),
        .out_target      (out_target),
        .out_ready       (out_ready),
        .global_time     (global_time),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        enable          = 1'b0;
        end_time        = 16'd100;
        q_valid         = 1'b0;
        q_time          = '0;
        q_id            = '0;
        core_new_ready  = '0;
        core_new_time   = '0;
        core_new_target = '0;
        out_ready       = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1;
        step();
        checks++;
        if ({done, err, out_valid, core_event_valid, global_time} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b err=%b ov=%b cev=%b gt=%0d required all 0",
                     done, err, out_valid, core_event_valid, global_time);
        end
        rst = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_done: got %b required 1", done);
        end
        checks++;
        if (global_time !== 16'd0) begin
            errors++;
            $display("FAIL reset_idle_gvt: got %0d required 0", global_time);
        end
        checks++;
        if (core_event_valid !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle_cev: got %b required 0000", core_event_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        enable  = 1'b1;
        q_valid = 1'b1;
        q_id    = 3'd2;
        q_time  = 16'd5;
        #1;
        checks++;
        if (q_pop !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: got %b required 1", q_pop);
        end
        step();
        q_valid = 1'b0;
        checks++;
        if ({core_event_valid, core_event_id, core_event_time} !== {4'b0001, 3'd2, 16'd5}) begin
            errors++;
            $display("FAIL single_dispatch: got cev=%b id=%0d t=%0d required 0001/2/5",
                     core_event_valid, core_event_id, core_event_time);
        end
        step();
        checks++;
        if (core_event_valid !== 4'b0000 || global_time !== 16'd5 || done !== 1'b0) begin
            errors++;
            $display("FAIL single_gvt: got cev=%b gt=%0d done=%b required 0000/5/0",
                     core_event_valid, global_time, done);
        end
        core_new_ready       = 4'b0001;
        core_new_time[15:0]  = 16'd12;
        core_new_target[2:0] = 3'd4;
        step();
        core_new_ready = '0;
        checks++;
        if ({out_valid, out_time, out_target} !== {1'b1, 16'd12, 3'd4}) begin
            errors++;
            $display("FAIL single_return: got ov=%b t=%0d tgt=%0d required 1/12/4",
                     out_valid, out_time, out_target);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got out_valid=%b required 0", out_valid);
        end
        step();
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b err=%b required 1/0", done, err);
        end
    endtask

    // Fills cores 0..3 with times 5..8; leaves time 9 at the queue head.
    task automatic fill_cores();
        logic [NCORE-1:0] exp_v;
        enable  = 1'b1;
        q_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q_time = 16'(5 + k);
            q_id   = 3'(k);
            #1;
            checks++;
            if (q_pop !== 1'b1) begin
                errors++;
                $display("FAIL fill_pop%0d: got %b required 1", k, q_pop);
            end
            step();
            exp_v = 4'(1 << k);
            checks++;
            if (core_event_valid !== exp_v || core_event_time !== 16'(5 + k)) begin
                errors++;
                $display("FAIL fill_dispatch%0d: got cev=%b t=%0d required %b/%0d",
                         k, core_event_valid, core_event_time, exp_v, 5 + k);
            end
        end
        q_time = 16'd9;
        q_id   = 3'd4;
    endtask

    task automatic test_fill();
        apply_reset();
        fill_cores();
        #1;
        checks++;
        if (q_pop !== 1'b0) begin
            errors++;
            $display("FAIL fill_full_pop: got %b required 0", q_pop);
        end
        step();
        checks++;
        if (core_event_valid !== 4'b0000 || core_event_time !== 16'd8) begin
            errors++;
            $display("FAIL fill_hold_bus: got cev=%b t=%0d required 0000/8",
                     core_event_valid, core_event_time);
        end
        step();
        checks++;
        if (global_time !== 16'd5 || q_pop !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL fill_gvt: got gt=%0d pop=%b done=%b required 5/0/0",
                     global_time, q_pop, done);
        end
    endtask

    task automatic test_rr_stall();
        apply_reset();
        fill_cores();
        q_valid                = 1'b0;
        core_new_ready         = 4'b1110;
        core_new_time[31:16]   = 16'd30;
        core_new_time[47:32]   = 16'd31;
        core_new_time[63:48]   = 16'd32;
        core_new_target[5:3]   = 3'd1;
        core_new_target[8:6]   = 3'd2;
        core_new_target[11:9]  = 3'd3;
        step();
        core_new_ready = '0;
        checks++;
        if ({out_valid, out_time, out_target} !== {1'b1, 16'd30, 3'd1}) begin
            errors++;
            $display("FAIL rr_first: got ov=%b t=%0d tgt=%0d required 1/30/1",
                     out_valid, out_time, out_target);
        end
        // Core 0 joins during the stall; the locked grant must not move to it.
        core_new_ready       = 4'b0001;
        core_new_time[15:0]  = 16'd40;
        core_new_target[2:0] = 3'd5;
        step();
        core_new_ready = '0;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if ({out_valid, out_time, out_target} !== {1'b1, 16'd30, 3'd1}) begin
                errors++;
                $display("FAIL rr_stall%0d: got ov=%b t=%0d tgt=%0d required 1/30/1",
                         s, out_valid, out_time, out_target);
            end
            if (s == 0) step();
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_time, out_target} !== {16'd31, 3'd2}) begin
            errors++;
            $display("FAIL rr_grant2: got t=%0d tgt=%0d required 31/2", out_time, out_target);
        end
        step();
        checks++;
        if ({out_time, out_target} !== {16'd32, 3'd3}) begin
            errors++;
            $display("FAIL rr_grant3: got t=%0d tgt=%0d required 32/3", out_time, out_target);
        end
        step();
        checks++;
        if ({out_valid, out_time, out_target} !== {1'b1, 16'd40, 3'd5}) begin
            errors++;
            $display("FAIL rr_grant0: got ov=%b t=%0d tgt=%0d required 1/40/5",
                     out_valid, out_time, out_target);
        end
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL rr_drained: got ov=%b err=%b required 0/0", out_valid, err);
        end
    endtask

    task automatic test_end_time();
        apply_reset();
        enable   = 1'b1;
        end_time = 16'd20;
        q_valid  = 1'b1;
        q_time   = 16'd20;
        q_id     = 3'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (q_pop !== 1'b0) begin
                errors++;
                $display("FAIL end_pop%0d: got %b required 0", c, q_pop);
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || core_event_valid !== 4'b0000 || global_time !== 16'd20) begin
            errors++;
            $display("FAIL end_done: got done=%b cev=%b gt=%0d required 1/0000/20",
                     done, core_event_valid, global_time);
        end
        q_time = 16'd19;
        #1;
        checks++;
        if (q_pop !== 1'b1) begin
            errors++;
            $display("FAIL end_below_pop: got %b required 1", q_pop);
        end
        step();
        q_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || core_event_valid !== 4'b0001) begin
            errors++;
            $display("FAIL end_below: got done=%b cev=%b required 0/0001", done, core_event_valid);
        end
    endtask

    task automatic test_enable_off();
        apply_reset();
        enable  = 1'b0;
        q_valid = 1'b1;
        q_time  = 16'd3;
        #1;
        checks++;
        if (q_pop !== 1'b0) begin
            errors++;
            $display("FAIL disabled_pop: got %b required 0", q_pop);
        end
        step();
        step();
        checks++;
        if (done !== 1'b0 || core_event_valid !== 4'b0000) begin
            errors++;
            $display("FAIL disabled_state: got done=%b cev=%b required 0/0000",
                     done, core_event_valid);
        end
    endtask

    task automatic test_err_and_rst();
        apply_reset();
        enable         = 1'b1;
        core_new_ready = 4'b0100;
        step();
        core_new_ready = '0;
        checks++;
        if (err !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_set: got err=%b ov=%b required 1/0", err, out_valid);
        end
        q_valid = 1'b1;
        q_time  = 16'd7;
        step();
        q_valid = 1'b0;
        checks++;
        if (err !== 1'b1 || core_event_valid !== 4'b0001) begin
            errors++;
            $display("FAIL err_sticky: got err=%b cev=%b required 1/0001", err, core_event_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({err, done, out_valid, core_event_valid, global_time, core_event_time} !== '0) begin
            errors++;
            $display("FAIL rst_mid: got err=%b done=%b ov=%b cev=%b gt=%0d t=%0d required all 0",
                     err, done, out_valid, core_event_valid, global_time, core_event_time);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rst_cores_idle: got done=%b required 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_rr_stall();
        test_end_time();
        test_enable_off();
        test_err_and_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
